uart_tx_fifo_ctrl: RTL and testbench
====================================

Name: uart_tx_fifo_ctrl

Overview:
Transmit-side buffer and launcher that sits directly upstream of the UART transmitter. The CPU/MMIO wrapper pushes bytes into an internal FIFO. The controller pops one byte at a time, presents it on tx_din with a one-cycle tx_start pulse, then waits for the transmitter's tx_done_tick before launching the next byte. Status outputs (full, empty, count, overflow, busy) are exposed for the MMIO register map.

Parameters:
DATA_BITS, 8, width of each FIFO entry and of tx_din
ADDR_WIDTH, 4, FIFO address width; depth = 2**ADDR_WIDTH (16)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
wr_en  input  1  push wr_data this cycle
wr_data  input  DATA_BITS  byte to enqueue
flush  input  1  synchronous FIFO clear
clr_overflow  input  1  clears sticky overflow flag
tx_done_tick  input  1  one-cycle pulse from transmitter at end of stop bit
tx_start  output  1  one-cycle launch pulse to transmitter (registered)
tx_din  output  DATA_BITS  byte for transmitter; stable from tx_start until next launch
full  output  1  count == depth
empty  output  1  count == 0
count  output  ADDR_WIDTH+1  number of stored entries, 0..depth
overflow  output  1  sticky: a write was attempted while full
busy  output  1  1 while a frame is in flight (state WAIT)

Behaviour:
- Reset is asynchronous, active-high, and may occur mid-frame. On reset: state=IDLE, rd_ptr=wr_ptr=0, tx_start=0, tx_din=0, overflow=0, busy=0, empty=1, full=0, count=0. No frame is resumed after reset.
- Pointers are ADDR_WIDTH+1 bits and wrap naturally. Addressing uses the low ADDR_WIDTH bits.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and low bits are equal.
  - count = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1).
- Write: wr_en && !full && !flush stores wr_data at wr_ptr and increments wr_ptr.
- Write while full (and !flush): data is dropped, FIFO is unchanged, overflow is set.
- A write while full is rejected even if a pop occurs in the same cycle; full is evaluated on the registered state.
- overflow: set has priority over a simultaneous clr_overflow. clr_overflow alone clears it.
- flush: sets rd_ptr <= wr_ptr.
  - A write in the same cycle is dropped and does not set overflow.
  - Flush does not abort a frame in flight; state, busy and tx_din are unaffected.
- FSM states, from a shared enum:
  - IDLE: if !empty && !flush, then on the clock edge: tx_din <= mem[rd_ptr], rd_ptr++, tx_start <= 1, state <= WAIT. Otherwise tx_start <= 0. A tx_done_tick received in IDLE is ignored.
  - WAIT: tx_start <= 0, so the pulse is exactly one cycle; busy=1. On tx_done_tick, state <= IDLE.
- Pop and push in the same cycle are both accepted when not full; count is unchanged.
- Latency: a write at edge N makes empty=0 after edge N. If IDLE, tx_start is high after edge N+1, i.e. 1 idle cycle between the write being visible and the launch.
- Back-to-back frames: tx_done_tick at edge M moves the FSM to IDLE. tx_start rises after edge M+1, by which time the transmitter has returned to idle, so no launch is lost.
- Data order is strict FIFO.
- tx_din holds its value between launches.

Decomposition:
- Package uart_pkg: typedef enum {IDLE, WAIT} tx_ctrl_state_t; localparam DEPTH = 2**ADDR_WIDTH is computed in-module.
- Sub-module uart_fifo (storage, pointers, full/empty/count, flush), instantiated once.
- The FSM and overflow logic live in uart_tx_fifo_ctrl.

Test Plan:
- Reset, then write 0xA5 -> tx_start pulses for exactly 1 cycle, 2 edges after the write; tx_din=0xA5; busy=1; empty=1.
- Write 0x01, 0x02, 0x03 back-to-back; respond with tx_done_tick 100 cycles after each start -> exactly three tx_start pulses with tx_din 0x01, 0x02, 0x03 in order; each start 1 cycle after the preceding tx_done_tick.
- Hold tx_done_tick low and write 17 bytes (first byte launched) -> count=16, full=1, 18th write sets overflow=1 and the FIFO contents are unchanged; clr_overflow -> overflow=0.
- Assert flush during WAIT with 5 entries queued -> count=0, empty=1, busy stays 1; after tx_done_tick no further tx_start.
- Assert reset mid-WAIT with 3 entries -> all outputs return to reset values immediately (asynchronously); no tx_start after release until a new write.
- Fill to 16, then write on the same cycle the pop occurs -> write is rejected and overflow is set. Separately, push plus pop at count=4 -> count stays 4.

Source files
------------

// File: rtl/uart_tx_fifo_ctrl_pkg.sv
// uart_pkg: shared launcher state type for the UART transmit path.
package uart_pkg;
    typedef enum logic {IDLE, WAIT} tx_ctrl_state_t;
endpackage

// File: rtl/uart_tx_fifo_ctrl_if.sv
// uart_tx_fifo_ctrl_if: MMIO-side push/status and transmitter-side launch signals.
interface uart_tx_fifo_ctrl_if #(
    parameter int DATA_BITS  = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_en;
    logic [DATA_BITS-1:0]  wr_data;
    logic                  flush;
    logic                  clr_overflow;
    logic                  tx_done_tick;
    logic                  tx_start;
    logic [DATA_BITS-1:0]  tx_din;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  busy;
    modport master (
        output wr_en, wr_data, flush, clr_overflow, tx_done_tick,
        input  tx_start, tx_din, full, empty, count, overflow, busy
    );
    modport slave (
        input  wr_en, wr_data, flush, clr_overflow, tx_done_tick,
        output tx_start, tx_din, full, empty, count, overflow, busy
    );
endinterface

// File: rtl/uart_tx_fifo_ctrl_fifo.sv
// uart_fifo: byte storage with wrap-bit pointers, status and synchronous flush.
module uart_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic                 flush_i,
    input  logic [DATA_BITS-1:0] wr_data_i,
    output logic [DATA_BITS-1:0] rd_data_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [ADDR_WIDTH:0]  count_o
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                 wr_ok;
    assign empty_o   = wr_ptr_q == rd_ptr_q;
    assign full_o    = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                       (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign rd_data_o = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    assign wr_ok     = push_i && !full_o && !flush_i;
    // Flush snaps the read pointer to the pre-edge write pointer; a same-cycle push is already blocked.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_ok};
        rd_ptr_d = flush_i ? wr_ptr_q : rd_ptr_q + {{ADDR_WIDTH{1'b0}}, pop_i && !empty_o};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data_i;
    end
endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl: buffers bytes and launches them one frame at a time into the UART transmitter.
module uart_tx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int ADDR_WIDTH = 4
) (
    input logic                clk,
    input logic                reset,
    uart_tx_fifo_ctrl_if.slave bus
);
    tx_ctrl_state_t       state_q, state_d;
    logic                 tx_start_q, tx_start_d;
    logic [DATA_BITS-1:0] tx_din_q, tx_din_d;
    logic                 overflow_q, overflow_d;
    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 fifo_full, fifo_empty;
    logic [ADDR_WIDTH:0]  fifo_count;
    logic                 launch;
    uart_fifo #(
        .DATA_BITS (DATA_BITS),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_i   (bus.wr_en),
        .pop_i    (launch),
        .flush_i  (bus.flush),
        .wr_data_i(bus.wr_data),
        .rd_data_o(fifo_rd_data),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (fifo_count)
    );
    assign launch = (state_q == IDLE) && !fifo_empty && !bus.flush;
    // Overflow set wins over a same-cycle clear so a rejected byte is never silently lost.
    always_comb begin
        state_d    = launch ? WAIT : (state_q == WAIT && bus.tx_done_tick) ? IDLE : state_q;
        tx_start_d = launch;
        tx_din_d   = launch ? fifo_rd_data : tx_din_q;
        overflow_d = (bus.wr_en && fifo_full && !bus.flush) ? 1'b1 :
                     bus.clr_overflow ? 1'b0 : overflow_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_din_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_din_q   <= tx_din_d;
            overflow_q <= overflow_d;
        end
    end
    assign bus.tx_start = tx_start_q;
    assign bus.tx_din   = tx_din_q;
    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.count    = fifo_count;
    assign bus.overflow = overflow_q;
    assign bus.busy     = state_q == WAIT;
endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// tb_uart_tx_fifo_ctrl: directed stimulus with a launch scoreboard for uart_tx_fifo_ctrl.
module tb_uart_tx_fifo_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_tx_fifo_ctrl_if #(.DATA_BITS(8), .ADDR_WIDTH(4)) bus ();
    uart_tx_fifo_ctrl #(.DATA_BITS(8), .ADDR_WIDTH(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [7:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int n_starts = 0;
    logic prev_start = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic done_pulse;
        bus.tx_done_tick = 1'b1;
        cyc();
        bus.tx_done_tick = 1'b0;
    endtask

    // Monitor: every launch must carry the next expected byte and last one cycle.
    always @(negedge clk) begin
        if (reset) prev_start = 1'b0;
        else begin
            if (bus.tx_start) begin
                n_starts++;
                check("start_width", int'(prev_start), 0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_start: tx_din=0x%0h with no byte expected at %0t", bus.tx_din, $time);
                end else check("tx_din_order", bus.tx_din, exp_q.pop_front());
            end
            prev_start = bus.tx_start;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int s;
        bus.wr_en = 1'b0;
        bus.wr_data = '0;
        bus.flush = 1'b0;
        bus.clr_overflow = 1'b0;
        bus.tx_done_tick = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc();
        check("rst_tx_start", bus.tx_start, 0);
        check("rst_tx_din", bus.tx_din, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_count", bus.count, 0);

        // Single byte launch latency
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hA5;
        exp_q.push_back(8'hA5);
        cyc();
        bus.wr_en = 1'b0;
        check("t1_empty_after_write", bus.empty, 0);
        check("t1_idle_gap", bus.tx_start, 0);
        cyc();
        check("t1_start", bus.tx_start, 1);
        check("t1_busy", bus.busy, 1);
        check("t1_empty_after_pop", bus.empty, 1);
        cyc();
        check("t1_pulse_end", bus.tx_start, 0);
        check("t1_busy_hold", bus.busy, 1);
        cyc(5);
        done_pulse();
        check("t1_busy_clear", bus.busy, 0);
        check("t1_din_hold", bus.tx_din, 8'hA5);

        // Back-to-back frames
        for (int i = 1; i <= 3; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 8'(i);
            exp_q.push_back(8'(i));
            cyc();
        end
        bus.wr_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(100);
            done_pulse();
            check("t2_gap", bus.tx_start, 0);
            check("t2_idle", bus.busy, 0);
            cyc();
            check("t2_relaunch", bus.tx_start, int'(k < 2));
        end
        check("t2_drained", exp_q.size(), 0);

        // Fill to full, overflow handling
        for (int i = 0; i < 17; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 8'(8'h10 + i);
            exp_q.push_back(8'(8'h10 + i));
            cyc();
        end
        check("t3_count_full", bus.count, 16);
        check("t3_full", bus.full, 1);
        check("t3_no_ovf_yet", bus.overflow, 0);
        bus.wr_data = 8'hEE;
        cyc();
        check("t3_ovf_set", bus.overflow, 1);
        check("t3_count_kept", bus.count, 16);
        bus.wr_data = 8'hEF;
        bus.clr_overflow = 1'b1;
        cyc();
        bus.wr_en = 1'b0;
        check("t3_ovf_priority", bus.overflow, 1);
        cyc();
        bus.clr_overflow = 1'b0;
        check("t3_ovf_clear", bus.overflow, 0);

        // Write while full on the same cycle as a pop
        bus.tx_done_tick = 1'b1;
        cyc();
        bus.tx_done_tick = 1'b0;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hEE;
        cyc();
        bus.wr_en = 1'b0;
        check("t6_ovf_on_pop", bus.overflow, 1);
        check("t6_count_after_pop", bus.count, 15);
        bus.clr_overflow = 1'b1;
        cyc();
        bus.clr_overflow = 1'b0;
        repeat (10) begin
            done_pulse();
            cyc(2);
        end
        check("t4_count_before_flush", bus.count, 5);
        check("t4_busy_before_flush", bus.busy, 1);

        // Flush during WAIT
        bus.flush = 1'b1;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h77;
        cyc();
        bus.flush = 1'b0;
        bus.wr_en = 1'b0;
        check("t4_count", bus.count, 0);
        check("t4_empty", bus.empty, 1);
        check("t4_busy", bus.busy, 1);
        check("t4_no_ovf", bus.overflow, 0);
        check("t4_din_kept", bus.tx_din, 8'h1B);
        repeat (5) void'(exp_q.pop_back());
        s = n_starts;
        done_pulse();
        cyc(5);
        check("t4_no_start", n_starts, s);
        check("t4_idle", bus.busy, 0);

        // Asynchronous reset mid-frame
        for (int i = 0; i < 4; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 8'(8'h31 + i);
            if (i == 0) exp_q.push_back(8'h31);
            cyc();
        end
        bus.wr_en = 1'b0;
        check("t5_count", bus.count, 3);
        check("t5_busy", bus.busy, 1);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_count", bus.count, 0);
        check("t5_rst_empty", bus.empty, 1);
        check("t5_rst_din", bus.tx_din, 0);
        check("t5_rst_start", bus.tx_start, 0);
        check("t5_rst_full", bus.full, 0);
        cyc();
        reset = 1'b0;
        s = n_starts;
        cyc(10);
        check("t5_no_resume", n_starts, s);
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h5A;
        exp_q.push_back(8'h5A);
        cyc();
        bus.wr_en = 1'b0;
        cyc();
        check("t5_new_launch", bus.tx_start, 1);
        cyc(3);
        done_pulse();

        // Push and pop together at count 4
        for (int i = 0; i < 5; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 8'(8'h41 + i);
            exp_q.push_back(8'(8'h41 + i));
            cyc();
        end
        bus.wr_en = 1'b0;
        check("t6_count4", bus.count, 4);
        bus.tx_done_tick = 1'b1;
        cyc();
        bus.tx_done_tick = 1'b0;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h46;
        exp_q.push_back(8'h46);
        cyc();
        bus.wr_en = 1'b0;
        check("t6_push_pop_count", bus.count, 4);
        check("t6_push_pop_start", bus.tx_start, 1);
        repeat (5) begin
            cyc(3);
            done_pulse();
        end
        cyc(3);
        check("t6_drained", exp_q.size(), 0);
        check("t6_final_count", bus.count, 0);
        check("t6_final_empty", bus.empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
